mem_access_stage: RTL and testbench

Memory-access stage of the RV32I pipeline: consumes the EX/MEM register bundle, performs loads/stores over a request/acknowledge data bus, and produces the registered MEM/WB bundle. Handles byte/halfword/word sizing, byte-lane alignment, load sign/zero extension, misalignment detection and bus timeout. It stalls the upstream pipeline while a bus transaction is outstanding.

---
 rtl/mem_access_stage.sv | 206 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// RV32I memory-access stage: turns the EX/MEM bundle into a single req/ack bus
// transaction when needed and emits the registered MEM/WB bundle.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [1:0]  wb_ctrl_in,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  output logic        stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        wb_valid,
  output logic [1:0]  wb_ctrl_out,
  output logic [4:0]  rd_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_data_out,
  output logic        fault_out
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic        TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES - 1);

  function automatic logic access_fault(logic rd, logic wr, logic [2:0] f3, logic [1:0] a);
    logic bad;
    bad = (rd & wr) | (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111) | (wr & f3[2]);
    bad = bad | ((f3[1:0] == 2'b01) & a[0]) | ((f3[1:0] == 2'b10) & (a != 2'b00));
    return bad;
  endfunction

  function automatic logic [3:0] byte_enables(logic [2:0] f3, logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(logic [2:0] f3, logic [31:0] sd);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{sd[7:0]}};
      2'b01:   w = {2{sd[15:0]}};
      default: w = sd;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extend(logic [2:0] f3, logic [1:0] a, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = w;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wb_valid_q, wb_valid_d, fault_q, fault_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] alu_q, alu_d, mdata_q, mdata_d;
  logic        mem_op_s, fault_s, timeout_s, stall_s;

  assign mem_op_s  = in_valid & (mem_rd | mem_wr);
  assign fault_s   = mem_op_s & access_fault(mem_rd, mem_wr, funct3, alu_result_in[1:0]);
  assign timeout_s = TO_EN & ~dbus_ack & (cnt_q == TO_LIMIT);

  // Next-state, bus and writeback computation; upstream holds inputs while stalled.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    wb_valid_d = wb_valid_q;
    ctrl_d     = ctrl_q;
    rd_d       = rd_q;
    alu_d      = alu_q;
    mdata_d    = mdata_q;
    fault_d    = fault_q;
    stall_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op_s && !fault_s) begin
          stall_s    = 1'b1;
          state_d    = BUSY;
          cnt_d      = 32'd0;
          req_d      = 1'b1;
          we_d       = mem_wr;
          addr_d     = {alu_result_in[31:2], 2'b00};
          be_d       = byte_enables(funct3, alu_result_in[1:0]);
          wdata_d    = store_lanes(funct3, store_data_in);
          wb_valid_d = 1'b0;
        end else begin
          wb_valid_d = in_valid;
          ctrl_d     = wb_ctrl_in;
          rd_d       = rd_in;
          alu_d      = alu_result_in;
          mdata_d    = 32'd0;
          fault_d    = fault_s;
        end
      end
      BUSY: begin
        if (dbus_ack || timeout_s) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          wb_valid_d = in_valid;
          ctrl_d     = wb_ctrl_in;
          rd_d       = rd_in;
          alu_d      = alu_result_in;
          mdata_d    = (dbus_ack && mem_rd) ? load_extend(funct3, alu_result_in[1:0], dbus_rdata) : 32'd0;
          fault_d    = ~dbus_ack;
        end else begin
          stall_s    = 1'b1;
          cnt_d      = cnt_q + 32'd1;
          wb_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      wb_valid_q <= 1'b0;
      ctrl_q     <= 2'd0;
      rd_q       <= 5'd0;
      alu_q      <= 32'd0;
      mdata_q    <= 32'd0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      ctrl_q     <= ctrl_d;
      rd_q       <= rd_d;
      alu_q      <= alu_d;
      mdata_q    <= mdata_d;
      fault_q    <= fault_d;
    end
  end

  assign stall          = stall_s;
  assign dbus_req       = req_q;
  assign dbus_we        = we_q;
  assign dbus_addr      = addr_q;
  assign dbus_be        = be_q;
  assign dbus_wdata     = wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_ctrl_out    = ctrl_q;
  assign rd_out         = rd_q;
  assign alu_result_out = alu_q;
  assign mem_data_out   = mdata_q;
  assign fault_out      = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a transaction-level model predicts the
// per-cycle bus/stall/writeback outputs, and one negedge process compares them.
module tb_mem_access_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [1:0]  wb_ctrl_in = 2'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [4:0]  rd_in = 5'd0;
  logic [31:0] alu_result_in = 32'd0, store_data_in = 32'd0;
  logic        dbus_ack = 1'b0;
  logic [31:0] dbus_rdata = 32'd0;
  logic        stall, dbus_req, dbus_we, wb_valid, fault_out;
  logic [31:0] dbus_addr, dbus_wdata, alu_result_out, mem_data_out;
  logic [3:0]  dbus_be;
  logic [1:0]  wb_ctrl_out;
  logic [4:0]  rd_out;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .wb_ctrl_in(wb_ctrl_in),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3), .rd_in(rd_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .stall(stall), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .wb_valid(wb_valid), .wb_ctrl_out(wb_ctrl_out),
    .rd_out(rd_out), .alu_result_out(alu_result_out), .mem_data_out(mem_data_out),
    .fault_out(fault_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs maintained by the model.
  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_addr = 32'd0, exp_wdata = 32'd0;
  logic [3:0]  exp_be = 4'd0;
  logic        exp_wbv = 1'b0, exp_fault = 1'b0;
  logic [1:0]  exp_ctrl = 2'd0;
  logic [4:0]  exp_rd = 5'd0;
  logic [31:0] exp_alu = 32'd0, exp_mdata = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_fault(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    if (rd && wr) return 1'b1;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (wr && f3 >= 3'd4) return 1'b1;
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    return 4'(((1 << n) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    int n = nbytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int n = nbytes(f3);
    logic [31:0] v, mask;
    v = w >> (8 * a[1:0]);
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Per-cycle comparison against the model, sampled away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("dbus_req", 32'(dbus_req), 32'(exp_req));
      chk("wb_valid", 32'(wb_valid), 32'(exp_wbv));
      if (exp_req) begin
        chk("dbus_we", 32'(dbus_we), 32'(exp_we));
        chk("dbus_addr", dbus_addr, exp_addr);
        chk("dbus_be", 32'(dbus_be), 32'(exp_be));
        chk("dbus_wdata", dbus_wdata, exp_wdata);
      end
      if (exp_wbv) begin
        chk("wb_ctrl_out", 32'(wb_ctrl_out), 32'(exp_ctrl));
        chk("rd_out", 32'(rd_out), 32'(exp_rd));
        chk("alu_result_out", alu_result_out, exp_alu);
        chk("mem_data_out", mem_data_out, exp_mdata);
        chk("fault_out", 32'(fault_out), 32'(exp_fault));
      end
    end
  end

  task automatic cycle_end();
    @(posedge clk);
    #1;
  endtask

  // ack_k: BUSY cycle (1-based) in which ack is given; -1 for never.
  task automatic run_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                        input int ack_k);
    logic flt, go, ack, to, done;
    in_valid = v; mem_rd = rd; mem_wr = wr; funct3 = f3;
    alu_result_in = a; store_data_in = sd;
    rd_in = a[6:2]; wb_ctrl_in = a[1:0] ^ 2'b10;
    dbus_ack = 1'b0; dbus_rdata = 32'd0;
    flt = v && (rd || wr) && m_fault(rd, wr, f3, a);
    go  = v && (rd || wr) && !flt;
    exp_stall = go; exp_req = 1'b0;
    cycle_end();
    if (!go) begin
      exp_wbv = v; exp_ctrl = wb_ctrl_in; exp_rd = rd_in; exp_alu = a;
      exp_mdata = 32'd0; exp_fault = flt;
    end else begin
      exp_wbv = 1'b0; exp_req = 1'b1; exp_we = wr;
      exp_addr = {a[31:2], 2'b00}; exp_be = m_be(f3, a); exp_wdata = m_wdata(f3, sd);
      done = 1'b0;
      for (int c = 1; !done && c <= TO; c++) begin
        ack = (c == ack_k); to = (c == TO);
        dbus_ack = ack; dbus_rdata = ack ? rdata : 32'hA5A5A5A5;
        exp_stall = !(ack || to);
        cycle_end();
        dbus_ack = 1'b0;
        if (ack || to) begin
          done = 1'b1; exp_req = 1'b0; exp_wbv = v;
          exp_ctrl = wb_ctrl_in; exp_rd = rd_in; exp_alu = a;
          exp_mdata = (ack && rd) ? m_load(f3, a, rdata) : 32'd0;
          exp_fault = !ack;
        end
      end
    end
  endtask

  task automatic idle(input logic late_ack);
    in_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    dbus_ack = late_ack; dbus_rdata = 32'h12345678;
    exp_stall = 1'b0; exp_req = 1'b0;
    cycle_end();
    dbus_ack = 1'b0;
    exp_wbv = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " dbus_req"}, 32'(dbus_req), 32'd0);
    chk({tag, " dbus_we"}, 32'(dbus_we), 32'd0);
    chk({tag, " dbus_addr"}, dbus_addr, 32'd0);
    chk({tag, " dbus_be"}, 32'(dbus_be), 32'd0);
    chk({tag, " dbus_wdata"}, dbus_wdata, 32'd0);
    chk({tag, " wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, " wb_ctrl_out"}, 32'(wb_ctrl_out), 32'd0);
    chk({tag, " rd_out"}, 32'(rd_out), 32'd0);
    chk({tag, " alu_result_out"}, alu_result_out, 32'd0);
    chk({tag, " mem_data_out"}, mem_data_out, 32'd0);
    chk({tag, " fault_out"}, 32'(fault_out), 32'd0);
  endtask

  initial begin
    // Pin the model with hand-computed values.
    chk("model be SB@1003", 32'(m_be(3'b000, 32'h1003)), 32'h8);
    chk("model wdata SB", m_wdata(3'b000, 32'hAABBCCDD), 32'hDDDDDDDD);
    chk("model wdata SH", m_wdata(3'b001, 32'h1234ABCD), 32'hABCDABCD);
    chk("model LB", m_load(3'b000, 32'h2002, 32'h0080FF11), 32'hFFFFFF80);
    chk("model LBU", m_load(3'b100, 32'h2002, 32'h0080FF11), 32'h00000080);
    chk("model LHU", m_load(3'b101, 32'h2002, 32'h0080FF11), 32'h00000080);
    chk("model LW@3001 fault", 32'(m_fault(1'b1, 1'b0, 3'b010, 32'h3001)), 32'd1);

    rst = 1'b1;
    cycle_end();
    cycle_end();
    check_all_zero("reset");
    chk("reset stall", 32'(stall), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_op(1'b1, 1'b0, 1'b0, 3'b000, 32'h00001234, 32'd0, 32'd0, 0);      // ALU op
    chk("alu literal", alu_result_out, 32'h00001234);
    run_op(1'b1, 1'b0, 1'b1, 3'b000, 32'h00001003, 32'hAABBCCDD, 32'd0, 2); // SB
    run_op(1'b1, 1'b1, 1'b0, 3'b000, 32'h00002002, 32'd0, 32'h0080FF11, 1); // LB
    chk("LB literal", mem_data_out, 32'hFFFFFF80);
    run_op(1'b1, 1'b1, 1'b0, 3'b100, 32'h00002002, 32'd0, 32'h0080FF11, 3); // LBU
    chk("LBU literal", mem_data_out, 32'h00000080);
    run_op(1'b1, 1'b1, 1'b0, 3'b101, 32'h00002002, 32'd0, 32'h0080FF11, 1); // LHU
    chk("LHU literal", mem_data_out, 32'h00000080);
    run_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h00003001, 32'd0, 32'd0, 1);       // LW misaligned
    chk("LW misaligned fault literal", 32'(fault_out), 32'd1);
    run_op(1'b1, 1'b1, 1'b0, 3'b001, 32'h00002001, 32'd0, 32'd0, 1);       // LH misaligned
    run_op(1'b1, 1'b0, 1'b1, 3'b100, 32'h00002000, 32'h11, 32'd0, 1);      // store funct3 100
    run_op(1'b1, 1'b1, 1'b1, 3'b010, 32'h00002000, 32'h11, 32'd0, 1);      // rd & wr
    run_op(1'b1, 1'b1, 1'b0, 3'b011, 32'h00002000, 32'd0, 32'd0, 1);       // funct3 011
    run_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h00002006, 32'h1234ABCD, 32'd0, 1); // SH upper
    run_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h00004000, 32'hCAFEF00D, 32'd0, 2); // SW
    run_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h00004000, 32'd0, 32'hDEADBEEF, 4); // ack at limit wins
    run_op(1'b1, 1'b1, 1'b0, 3'b001, 32'h00002002, 32'd0, 32'h80010000, 1); // LH sign
    run_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h00004000, 32'd0, 32'd0, 1);       // not valid
    run_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h00005000, 32'd0, 32'd0, -1);      // timeout
    chk("timeout fault literal", 32'(fault_out), 32'd1);
    idle(1'b1);                                                            // late ack
    idle(1'b0);

    // Reset during the second BUSY cycle abandons the transaction.
    chk_en = 1'b0;
    in_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010;
    alu_result_in = 32'h00006000; rd_in = 5'd7; wb_ctrl_in = 2'b11;
    cycle_end();
    cycle_end();
    rst = 1'b1;
    cycle_end();
    check_all_zero("mid-busy reset");
    rst = 1'b0; in_valid = 1'b0; mem_rd = 1'b0; dbus_ack = 1'b1;
    cycle_end();
    dbus_ack = 1'b0;
    chk("post-reset ack wb_valid", 32'(wb_valid), 32'd0);
    chk("post-reset ack dbus_req", 32'(dbus_req), 32'd0);
    exp_stall = 1'b0; exp_req = 1'b0; exp_wbv = 1'b0;
    chk_en = 1'b1;
    run_op(1'b1, 1'b1, 1'b0, 3'b000, 32'h00002003, 32'd0, 32'h7F000000, 1); // LB after reset
    idle(1'b0);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
